// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_c;
  logic             br_nxt_c;
  logic             last_c;
  logic [WIDTH-1:0] res_nxt_c;

  // One full-subtractor slice acting on the current LSBs of the working operands.
  assign d_c       = sa[0] ^ sb[0] ^ br;
  assign br_nxt_c  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last_c    = (cnt == CW'(WIDTH - 1));
  assign res_nxt_c = (res >> 1) | (WIDTH'(d_c) << (WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
            res <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt_c;
          res <= res_nxt_c;
          cnt <= cnt + CW'(1);
          if (last_c) begin
            diff <= res_nxt_c;
            bout <= br_nxt_c;
`ifdef SUB_OVF_EN
            // On the last bit sa[0]/sb[0] are the captured operand sign bits.
            ovf  <= (sa[0] ^ sb[0]) & (d_c ^ sa[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
